// File: rtl/uart_bytes_rx.sv
// Multi-byte UART receiver: 8N1 bit receiver plus word assembly.
// Build with UART_BYTES_RX_TIMEOUT_EN to drop stale partial words.
//
// Ports:
//   sys_clk            system clock
//   sys_rst_n          asynchronous reset, active low
//   uart_rxd           serial line, asynchronous to sys_clk
//   uart_bytes_data    last complete word, first byte in the low lane
//   uart_bytes_done    1-cycle pulse, uart_bytes_data valid from this cycle
//   uart_frame_err     1-cycle pulse, stop bit sampled low
//   uart_bytes_timeout 1-cycle pulse, partial word dropped after idle
module uart_bytes_rx #(
    parameter int BYTES        = 2,
    parameter int BPS          = 9_600,
    parameter int CLK_FRE      = 50_000_000,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               uart_rxd,
    output logic [BYTES*8-1:0] uart_bytes_data,
    output logic               uart_bytes_done,
    output logic               uart_frame_err,
    output logic               uart_bytes_timeout
);

    localparam int BPS_CNT = CLK_FRE / BPS;
    localparam int CNT_W   = $clog2(BPS_CNT);
    localparam int BC_W    = $clog2(BYTES) + 1;

    localparam logic [CNT_W-1:0] SMP  = CNT_W'(BPS_CNT / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BPS_CNT - 1);
    localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state, state_nxt;

    logic               rxd_s1, rxd_s2, rxd_d;
    logic [CNT_W-1:0]   clk_cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shift_reg;
    logic [BC_W-1:0]    byte_cnt;
    logic [BYTES*8-1:0] partial;
    logic [BYTES*8-1:0] word_nxt;

    logic start_det, at_smp, at_last, stop_smp, timeout_hit;

    // rxd_d is the previous synchronized value, for edge detection.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_d  <= 1'b1;
        end else begin
            rxd_s1 <= uart_rxd;
            rxd_s2 <= rxd_s1;
            rxd_d  <= rxd_s2;
        end
    end

    assign start_det = rxd_d & ~rxd_s2;
    assign at_smp    = (clk_cnt == SMP);
    assign at_last   = (clk_cnt == LAST);
    assign stop_smp  = (state == STOP) && at_smp;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start_det) state_nxt = START;
            START: begin
                if (at_smp && rxd_s2) state_nxt = IDLE;
                else if (at_last)     state_nxt = DATA;
            end
            DATA:  if (at_last && bit_cnt == 3'd7) state_nxt = STOP;
            // Leave at mid stop bit so a back-to-back start edge is seen.
            STOP:  if (at_smp) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Word as it would look with the current byte merged in.
    always_comb begin
        word_nxt = partial;
        word_nxt[8*byte_cnt +: 8] = shift_reg;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (state == IDLE || state_nxt == IDLE) clk_cnt <= '0;
            else if (at_last)                       clk_cnt <= '0;
            else                                    clk_cnt <= clk_cnt + 1'b1;

            if (state == START)             bit_cnt <= '0;
            else if (state == DATA && at_last) bit_cnt <= bit_cnt + 1'b1;

            if (state == DATA && at_smp)
                shift_reg <= {rxd_s2, shift_reg[7:1]};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            byte_cnt           <= '0;
            partial            <= '0;
            uart_bytes_data    <= '0;
            uart_bytes_done    <= 1'b0;
            uart_frame_err     <= 1'b0;
            uart_bytes_timeout <= 1'b0;
        end else begin
            uart_bytes_done    <= 1'b0;
            uart_frame_err     <= 1'b0;
            uart_bytes_timeout <= 1'b0;
            if (stop_smp) begin
                if (rxd_s2) begin
                    if (byte_cnt == LAST_BYTE) begin
                        uart_bytes_data <= word_nxt;
                        uart_bytes_done <= 1'b1;
                        byte_cnt        <= '0;
                        partial         <= '0;
                    end else begin
                        partial  <= word_nxt;
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end else begin
                    uart_frame_err <= 1'b1;
                    byte_cnt       <= '0;
                    partial        <= '0;
                end
            end else if (timeout_hit) begin
                uart_bytes_timeout <= 1'b1;
                byte_cnt           <= '0;
                partial            <= '0;
            end
        end
    end

`ifdef UART_BYTES_RX_TIMEOUT_EN
    localparam int TO_CYC = TIMEOUT_BITS * BPS_CNT;
    localparam int TO_W   = $clog2(TO_CYC + 1);

    logic [TO_W-1:0] idle_cnt;
    logic            idle_run;

    assign idle_run = (state == IDLE) && (byte_cnt != '0) && !start_det;
    assign timeout_hit = idle_run && (idle_cnt == TO_W'(TO_CYC - 1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)       idle_cnt <= '0;
        else if (!idle_run)   idle_cnt <= '0;
        else if (timeout_hit) idle_cnt <= '0;
        else                  idle_cnt <= idle_cnt + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_uart_bytes_rx.sv
// Directed bench for uart_bytes_rx, 2-byte and 4-byte instances.
// Bit period is 10 sys_clk cycles.
module tb_uart_bytes_rx;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic rxd2 = 1'b1;
    logic rxd4 = 1'b1;

    logic [15:0] data2;
    logic [31:0] data4;
    logic done2, err2, to2, done4, err4, to4;

    always #10 sys_clk = ~sys_clk;

    uart_bytes_rx #(.BYTES(2), .BPS(5_000_000), .CLK_FRE(50_000_000),
                    .TIMEOUT_BITS(20)) u_dut2 (
        .sys_clk            (sys_clk),
        .sys_rst_n          (sys_rst_n),
        .uart_rxd           (rxd2),
        .uart_bytes_data    (data2),
        .uart_bytes_done    (done2),
        .uart_frame_err     (err2),
        .uart_bytes_timeout (to2)
    );

    uart_bytes_rx #(.BYTES(4), .BPS(5_000_000), .CLK_FRE(50_000_000),
                    .TIMEOUT_BITS(20)) u_dut4 (
        .sys_clk            (sys_clk),
        .sys_rst_n          (sys_rst_n),
        .uart_rxd           (rxd4),
        .uart_bytes_data    (data4),
        .uart_bytes_done    (done4),
        .uart_frame_err     (err4),
        .uart_bytes_timeout (to4)
    );

    int n_chk = 0;
    int n_pass = 0;

    int done2_n = 0, err2_n = 0, to2_n = 0;
    int done4_n = 0, err4_n = 0;
    int excl_n = 0, wide_n = 0;
    logic [15:0] word2 = '0;
    logic [31:0] word4_first = '0, word4_last = '0;
    logic pd2 = 0, pe2 = 0, pt2 = 0, pd4 = 0;

    always @(negedge sys_clk) begin
        if (done2) begin
            done2_n++;
            word2 = data2;
        end
        if (err2) err2_n++;
        if (to2) to2_n++;
        if (done4) begin
            if (done4_n == 0) word4_first = data4;
            word4_last = data4;
            done4_n++;
        end
        if (err4) err4_n++;
        if (done2 && err2) excl_n++;
        if ((done2 && pd2) || (err2 && pe2) || (to2 && pt2)) wide_n++;
        if (done4 && pd4) wide_n++;
        pd2 = done2;
        pe2 = err2;
        pt2 = to2;
        pd4 = done4;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic drive(input bit sel4, input logic v, input int n);
        if (sel4) rxd4 = v;
        else      rxd2 = v;
        idle(n);
    endtask

    task automatic send(input bit sel4, input logic [7:0] b,
                        input logic stop);
        drive(sel4, 1'b0, 10);
        for (int i = 0; i < 8; i++) drive(sel4, b[i], 10);
        drive(sel4, stop, 10);
        if (sel4) rxd4 = 1'b1;
        else      rxd2 = 1'b1;
    endtask

    int bd, be, bt;

    initial begin
        idle(5);
        check("rst_data2", 32'(data2), 32'h0);
        check("rst_done2", 32'(done2), 32'h0);
        check("rst_err2", 32'(err2), 32'h0);
        check("rst_to2", 32'(to2), 32'h0);
        check("rst_data4", data4, 32'h0);
        check("rst_done4", 32'(done4), 32'h0);
        sys_rst_n = 1'b1;
        idle(20);

        // 1: clean two-byte word
        bd = done2_n; be = err2_n;
        send(0, 8'h34, 1'b1);
        check("t1_nodone_half", 32'(done2_n - bd), 0);
        send(0, 8'h12, 1'b1);
        idle(20);
        check("t1_done", 32'(done2_n - bd), 1);
        check("t1_data", 32'(word2), 32'h1234);
        check("t1_err", 32'(err2_n - be), 0);

        // 2: short low glitch is rejected
        bd = done2_n; be = err2_n;
        drive(0, 1'b0, 3);
        drive(0, 1'b1, 150);
        check("t2_done", 32'(done2_n - bd), 0);
        check("t2_err", 32'(err2_n - be), 0);
        check("t2_data", 32'(data2), 32'h1234);

        // 3: framing error, then a good word
        bd = done2_n; be = err2_n;
        send(0, 8'h77, 1'b0);
        idle(20);
        check("t3_err", 32'(err2_n - be), 1);
        check("t3_nodone", 32'(done2_n - bd), 0);
        send(0, 8'hAB, 1'b1);
        send(0, 8'hCD, 1'b1);
        idle(20);
        check("t3_done", 32'(done2_n - bd), 1);
        check("t3_data", 32'(word2), 32'hCDAB);
        check("t3_err_once", 32'(err2_n - be), 1);

        // 4: long gap after the first byte
        bd = done2_n; bt = to2_n;
        send(0, 8'h55, 1'b1);
        idle(250);
        send(0, 8'h11, 1'b1);
        send(0, 8'h22, 1'b1);
        idle(20);
`ifdef UART_BYTES_RX_TIMEOUT_EN
        check("t4_timeout", 32'(to2_n - bt), 1);
        check("t4_done", 32'(done2_n - bd), 1);
        check("t4_data", 32'(word2), 32'h2211);
`else
        check("t4_timeout", 32'(to2_n - bt), 0);
        check("t4_done", 32'(done2_n - bd), 1);
        check("t4_data", 32'(word2), 32'h1155);
`endif

        // 5: reset in the middle of a byte
        send(0, 8'h99, 1'b1);
        idle(10);
        drive(0, 1'b0, 10);
        drive(0, 1'b1, 10);
        drive(0, 1'b0, 10);
        drive(0, 1'b1, 5);
        be = err2_n; bd = done2_n;
        sys_rst_n = 1'b0;
        rxd2 = 1'b1;
        idle(2);
        check("t5_rst_data", 32'(data2), 32'h0);
        check("t5_rst_done", 32'(done2), 32'h0);
        sys_rst_n = 1'b1;
        idle(30);
        check("t5_no_err", 32'(err2_n - be), 0);
        check("t5_no_done", 32'(done2_n - bd), 0);
        send(0, 8'h0F, 1'b1);
        send(0, 8'hF0, 1'b1);
        idle(20);
        check("t5_done", 32'(done2_n - bd), 1);
        check("t5_data", 32'(word2), 32'hF00F);

        // 6: four-byte words, back to back
        bd = done4_n;
        for (int k = 0; k < 2; k++) begin
            send(1, 8'hEF, 1'b1);
            send(1, 8'hCD, 1'b1);
            send(1, 8'hAB, 1'b1);
            send(1, 8'h89, 1'b1);
        end
        idle(20);
        check("t6_done", 32'(done4_n - bd), 2);
        check("t6_word1", word4_first, 32'h89ABCDEF);
        check("t6_word2", word4_last, 32'h89ABCDEF);
        check("t6_err", 32'(err4_n), 0);

        check("done_err_excl", 32'(excl_n), 0);
        check("pulse_width", 32'(wide_n), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
